// File: rtl/id_hazard_scoreboard_if.sv
// Decode-to-EX hazard unit bus: decoded instruction fields in, issue
// decision and registered EX control fields out.
interface id_hazard_scoreboard_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   id_valid;
  logic [REG_ADDR_W-1:0]  id_rs;
  logic [REG_ADDR_W-1:0]  id_rt;
  logic                   id_uses_rs;
  logic                   id_uses_rt;
  logic [REG_ADDR_W-1:0]  id_rd;
  logic                   id_reg_write;
  logic                   id_mem_read;
  logic                   id_branch;
  logic                   flush;
  logic                   ex_ready;
  logic                   id_ready;
  logic                   stall;
  logic                   ex_valid;
  logic [REG_ADDR_W-1:0]  ex_rd;
  logic                   ex_reg_write;
  logic                   ex_mem_read;
  logic [STALL_CNT_W-1:0] stall_count;

  // Decode stage side: presents the instruction, observes the decision.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read, id_branch, flush, ex_ready,
    input  id_ready, stall, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
           stall_count
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read, id_branch, flush, ex_ready,
    output id_ready, stall, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
           stall_count
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard unit built on a per-register scoreboard of pending
// writes. Each register holds the number of cycles until its value can be
// forwarded; sources are compared against that count to decide
// issue / stall / bubble, and the issued control fields are registered for EX.
module id_hazard_scoreboard #(
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_LAT    = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  id_hazard_scoreboard_if.slave bus
);
  localparam int NREGS = 2 ** REG_ADDR_W;
  localparam int CNT_W = $clog2(LOAD_LAT + 2);

  localparam logic [CNT_W-1:0]       CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]       LOAD_SET = CNT_W'(LOAD_LAT + 1);
  localparam logic [REG_ADDR_W-1:0]  REG_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  logic [CNT_W-1:0]       sb_s [NREGS];
  logic [CNT_W-1:0]       rs_cnt_s;
  logic [CNT_W-1:0]       rt_cnt_s;
  logic                   rs_haz_s;
  logic                   rt_haz_s;
  logic                   hazard_s;
  logic                   stall_s;
  logic                   issue_s;
  logic                   set_s;
  logic [CNT_W-1:0]       set_val_s;

  logic                   ex_valid_r;
  logic [REG_ADDR_W-1:0]  ex_rd_r;
  logic                   ex_reg_write_r;
  logic                   ex_mem_read_r;
  logic [STALL_CNT_W-1:0] stall_count_r;

  // Source hazard detection against the pre-update scoreboard. A branch
  // consumes its sources in ID, so it needs the count fully drained; other
  // instructions can take the value through forwarding once it reaches 1.
  always_comb begin
    rs_cnt_s  = sb_s[bus.id_rs];
    rt_cnt_s  = sb_s[bus.id_rt];
    rs_haz_s  = 1'b0;
    rt_haz_s  = 1'b0;
    if (bus.id_branch) begin
      rs_haz_s = bus.id_uses_rs && (bus.id_rs != REG_ZERO) && (rs_cnt_s > CNT_ZERO);
      rt_haz_s = bus.id_uses_rt && (bus.id_rt != REG_ZERO) && (rt_cnt_s > CNT_ZERO);
    end else begin
      rs_haz_s = bus.id_uses_rs && (bus.id_rs != REG_ZERO) && (rs_cnt_s > CNT_ONE);
      rt_haz_s = bus.id_uses_rt && (bus.id_rt != REG_ZERO) && (rt_cnt_s > CNT_ONE);
    end
    hazard_s  = rs_haz_s || rt_haz_s;
    // Flush kills the instruction, so it can neither stall nor issue.
    stall_s   = bus.id_valid && !bus.flush && hazard_s;
    issue_s   = bus.id_valid && bus.ex_ready && !bus.flush && !hazard_s;
    set_s     = issue_s && bus.id_reg_write && (bus.id_rd != REG_ZERO);
    set_val_s = bus.id_mem_read ? LOAD_SET : CNT_ONE;
  end

  assign bus.stall        = stall_s;
  assign bus.id_ready     = bus.ex_ready && !stall_s;
  assign bus.ex_valid     = ex_valid_r;
  assign bus.ex_rd        = ex_rd_r;
  assign bus.ex_reg_write = ex_reg_write_r;
  assign bus.ex_mem_read  = ex_mem_read_r;
  assign bus.stall_count  = stall_count_r;

  // One pending-write counter per register; register 0 is hard-wired to zero.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
    if (gi == 0) begin : g_zero
      assign sb_s[gi] = CNT_ZERO;
    end else begin : g_cnt
      logic [CNT_W-1:0] cnt_r;

      // Set on an issued write (overrides any pending value), else count down.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_r <= CNT_ZERO;
        end else if (bus.ex_ready) begin
          if (set_s && (bus.id_rd == REG_ADDR_W'(gi))) begin
            cnt_r <= set_val_s;
          end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end else begin
          cnt_r <= cnt_r;
        end
      end

      assign sb_s[gi] = cnt_r;
    end
  end

  // ID/EX control register: issued fields or a bubble; frozen while EX is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r     <= 1'b0;
      ex_rd_r        <= REG_ZERO;
      ex_reg_write_r <= 1'b0;
      ex_mem_read_r  <= 1'b0;
    end else if (bus.ex_ready) begin
      if (issue_s) begin
        ex_valid_r     <= 1'b1;
        ex_rd_r        <= bus.id_rd;
        ex_reg_write_r <= bus.id_reg_write;
        ex_mem_read_r  <= bus.id_mem_read;
      end else begin
        ex_valid_r     <= 1'b0;
        ex_rd_r        <= REG_ZERO;
        ex_reg_write_r <= 1'b0;
        ex_mem_read_r  <= 1'b0;
      end
    end else begin
      ex_valid_r     <= ex_valid_r;
      ex_rd_r        <= ex_rd_r;
      ex_reg_write_r <= ex_reg_write_r;
      ex_mem_read_r  <= ex_mem_read_r;
    end
  end

  // Saturating count of cycles spent stalled while the pipeline advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= {STALL_CNT_W{1'b0}};
    end else if (bus.ex_ready && stall_s && (stall_count_r != STALL_MAX)) begin
      stall_count_r <= stall_count_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard. Two instances share the stimulus:
// u1 (LOAD_LAT=1, 16-bit counter) and u3 (LOAD_LAT=3, 2-bit counter to reach
// saturation). Expected EX fields are queued when a step is driven and
// compared after the clock edge.
module tb_id_hazard_scoreboard;
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ex_t;

  logic clk;
  logic rst_n;
  logic sel3;

  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic       id_branch, flush, ex_ready;
  logic [4:0] id_rs, id_rt, id_rd;

  id_hazard_scoreboard_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) if1 ();
  id_hazard_scoreboard_if #(.REG_ADDR_W(5), .STALL_CNT_W(2))  if3 ();

  assign if1.id_valid = id_valid;     assign if3.id_valid = id_valid;
  assign if1.id_rs = id_rs;           assign if3.id_rs = id_rs;
  assign if1.id_rt = id_rt;           assign if3.id_rt = id_rt;
  assign if1.id_uses_rs = id_uses_rs; assign if3.id_uses_rs = id_uses_rs;
  assign if1.id_uses_rt = id_uses_rt; assign if3.id_uses_rt = id_uses_rt;
  assign if1.id_rd = id_rd;           assign if3.id_rd = id_rd;
  assign if1.id_reg_write = id_reg_write; assign if3.id_reg_write = id_reg_write;
  assign if1.id_mem_read = id_mem_read;   assign if3.id_mem_read = id_mem_read;
  assign if1.id_branch = id_branch;   assign if3.id_branch = id_branch;
  assign if1.flush = flush;           assign if3.flush = flush;
  assign if1.ex_ready = ex_ready;     assign if3.ex_ready = ex_ready;

  id_hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(1), .STALL_CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  id_hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(3), .STALL_CNT_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));

  logic        obs_stall, obs_id_ready;
  ex_t         obs_ex;
  logic [15:0] obs_cnt;
  assign obs_stall    = sel3 ? if3.stall : if1.stall;
  assign obs_id_ready = sel3 ? if3.id_ready : if1.id_ready;
  assign obs_ex       = sel3 ? {if3.ex_valid, if3.ex_rd, if3.ex_reg_write, if3.ex_mem_read}
                             : {if1.ex_valid, if1.ex_rd, if1.ex_reg_write, if1.ex_mem_read};
  assign obs_cnt      = sel3 ? {14'd0, if3.stall_count} : if1.stall_count;

  int          checks = 0;
  int          errors = 0;
  ex_t         exp_q[$];
  ex_t         last_exp;
  logic [15:0] exp_cnt;
  logic [15:0] cnt_max;

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_rd = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_branch = 1'b0;
    flush = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk({tag, ":ex_valid"}, {31'd0, obs_ex.v}, 32'd0);
    chk({tag, ":ex_rd"}, {27'd0, obs_ex.rd}, 32'd0);
    chk({tag, ":ex_rw_mr"}, {30'd0, obs_ex.rw, obs_ex.mr}, 32'd0);
    chk({tag, ":stall_count"}, {16'd0, obs_cnt}, 32'd0);
    exp_q.delete();
    last_exp = '0;
    exp_cnt  = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One ID cycle: drive, check the combinational decision, queue the
  // expected EX fields, then compare them after the edge.
  task automatic step(input string tag, input logic v, input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic br, input logic fl,
                      input logic rdy, input logic exp_stall);
    ex_t e;
    @(negedge clk);
    id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_branch = br;
    flush = fl; ex_ready = rdy;
    #1;
    chk({tag, ":stall"}, {31'd0, obs_stall}, {31'd0, exp_stall});
    chk({tag, ":id_ready"}, {31'd0, obs_id_ready}, {31'd0, (rdy && !exp_stall)});
    if (rdy) begin
      if (v && !fl && !exp_stall) e = '{v: 1'b1, rd: rd, rw: rw, mr: mr};
      else e = '0;
      last_exp = e;
      if (exp_stall && (exp_cnt != cnt_max)) exp_cnt = exp_cnt + 16'd1;
    end else begin
      e = last_exp;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ":queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ":ex"}, {24'd0, obs_ex}, {24'd0, e});
    end
    chk({tag, ":stall_count"}, {16'd0, obs_cnt}, {16'd0, exp_cnt});
  endtask

  // Directed sequence.
  initial begin
    rst_n = 1'b0; sel3 = 1'b0; cnt_max = 16'hFFFF;
    last_exp = '0; exp_cnt = 16'd0;
    idle();
    do_reset("init");

    // lw r5 ; add r6,r5,r1 : one stall, one bubble
    step("lu_lw",   1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("lu_add0", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("lu_add1", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // lw r5 pending (R=2), reset mid-run, dependant must not stall
    step("rst_lw",  1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset("midrst");
    step("rst_add", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // add r5 ; beq r5,r0 : one stall
    step("ab_add",  1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ab_beq0", 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("ab_beq1", 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // lw r5 ; beq r5,r0 : two stalls
    step("lb_lw",   1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("lb_beq0", 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("lb_beq1", 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("lb_beq2", 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // lw r7 ; add r8,r7 flushed ; beq r8,r0 sees no pending write on r8
    step("fl_lw",   1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("fl_add",  1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("fl_beq",  1'b1, 5'd8, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Backpressure during a load-use stall: everything frozen for 4 cycles
    step("bp_lw",   1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      step("bp_hold", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("bp_stall", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("bp_issue", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // WAW: lw r5 ; add r5 ; sub r8,r5 issues without stall
    step("waw_lw",  1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("waw_add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("waw_sub", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Writes to r0 are never tracked
    step("r0_lw",   1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("r0_beq",  1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // LOAD_LAT=3 instance with a 2-bit stall counter
    sel3 = 1'b1; cnt_max = 16'd3;
    do_reset("sel3");
    step("l3_lw",   1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("l3_stall", 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("l3_add",  1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("sat_lw",  1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("sat_stall", 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("sat_add", 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("w3_lw",   1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("w3_add",  1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("w3_sub",  1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
